// File: rtl/softmax_row_packer.sv
// Packs the serial softmax output stream into N-element row words and
// presents them through a ping-pong buffer pair on a valid/ready interface.
module softmax_row_packer #(
    parameter  int D_W = 8,
    parameter  int N   = 32,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [D_W-1:0]   in_data,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [N*D_W-1:0] row_data,
    output logic [IW-1:0]    row_idx,
    output logic             row_last,
    output logic             matrix_done,
    output logic             overflow
);

    logic [N-1:0][D_W-1:0] buf_q [2];
    logic [1:0][IW-1:0]    tag_q, tag_d;
    logic [1:0]            full_q, full_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]         col_q, col_d;
    logic [IW-1:0]         row_q, row_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic cap, col_last, hs;

    // The write buffer is always the one rd_ptr is not presenting unless both
    // are empty, so a capture never lands in the buffer being handshaken.
    assign cap      = in_valid && enable && !clear && !full_q[wr_ptr_q];
    assign col_last = (col_q == IW'(N-1));
    assign hs       = full_q[rd_ptr_q] && row_ready && !clear;

    always_comb begin
        tag_d    = tag_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        col_d    = col_q;
        row_d    = row_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (clear) begin
            tag_d    = '0;
            full_d   = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            col_d    = '0;
            row_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (in_valid && enable && full_q[wr_ptr_q])
                ovf_d = 1'b1;
            if (cap) begin
                if (col_last) begin
                    col_d            = '0;
                    full_d[wr_ptr_q] = 1'b1;
                    tag_d[wr_ptr_q]  = row_q;
                    wr_ptr_d         = ~wr_ptr_q;
                    row_d            = (row_q == IW'(N-1)) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (hs) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
                done_d           = (tag_q[rd_ptr_q] == IW'(N-1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Data storage needs no reset: every lane is rewritten before a buffer is
    // marked full, and the outputs are gated by row_valid.
    always_ff @(posedge clk) begin
        if (cap)
            buf_q[wr_ptr_q][col_q] <= in_data;
    end

    assign row_valid   = full_q[rd_ptr_q];
    assign row_data    = row_valid ? buf_q[rd_ptr_q] : '0;
    assign row_idx     = row_valid ? tag_q[rd_ptr_q] : '0;
    assign row_last    = row_valid && (tag_q[rd_ptr_q] == IW'(N-1));
    assign matrix_done = done_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_softmax_row_packer.sv
// Randomized bench for softmax_row_packer against a queue-based row model.
module tb_softmax_row_packer;
    localparam int D_W = 8;
    localparam int N   = 32;
    localparam int IW  = $clog2(N);
    localparam int RW  = N * D_W;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0, clear = 1'b0, in_valid = 1'b0, row_ready = 1'b0;
    logic [D_W-1:0] in_data = '0;
    logic           row_valid, row_last, matrix_done, overflow;
    logic [RW-1:0]  row_data;
    logic [IW-1:0]  row_idx;

    softmax_row_packer #(.D_W(D_W), .N(N)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .row_valid(row_valid),
        .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx),
        .row_last(row_last), .matrix_done(matrix_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: completed rows wait in a FIFO of depth two; partial row in m_part.
    logic [RW-1:0] mq[$];
    int            mt[$];
    logic [RW-1:0] m_part = '0;
    int            m_col = 0, m_row = 0, m_cnt = 0;
    bit            m_ovf = 0, m_done = 0, m_pop = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            mq.delete(); mt.delete();
            m_col = 0; m_row = 0; m_ovf = 0; m_done = 0;
        end else begin
            m_cnt  = mq.size();
            m_pop  = row_ready && (m_cnt > 0);
            m_done = m_pop && (mt[0] == N-1);
            if (in_valid && enable) begin
                if (m_cnt == 2) m_ovf = 1;
                else begin
                    m_part[m_col*D_W +: D_W] = in_data;
                    m_col++;
                    if (m_col == N) begin
                        mq.push_back(m_part); mt.push_back(m_row);
                        m_col = 0; m_row = (m_row + 1) % N;
                    end
                end
            end
            if (m_pop) begin
                void'(mq.pop_front()); void'(mt.pop_front());
            end
        end
    end

    int checks = 0, failures = 0;
    int hs_cnt = 0, done_cnt = 0, last_cnt = 0;
    bit cnt_en = 0;
    logic [RW-1:0] exp_row;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input bit en, input logic [D_W-1:0] d);
        @(posedge clk); #1;
        in_valid = v; enable = en; in_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 1, '0);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1; in_valid = 0;
        @(posedge clk); #1;
        clear = 0;
    endtask

    task automatic wait_valid(input int budget);
        int i;
        i = 0;
        while (!row_valid && i < budget) begin
            @(posedge clk); #1; i++;
        end
        chk("wait_row_valid", {255'd0, row_valid}, 1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                chk("row_valid", {255'd0, row_valid}, (mq.size() > 0));
                if (mq.size() > 0) begin
                    chk("row_data", row_data, mq[0]);
                    chk("row_idx", RW'(row_idx), RW'(mt[0]));
                    chk("row_last", {255'd0, row_last}, (mt[0] == N-1));
                end
                chk("matrix_done", {255'd0, matrix_done}, m_done);
                chk("overflow", {255'd0, overflow}, m_ovf);
                if (cnt_en && row_valid && row_ready) begin
                    hs_cnt++;
                    if (row_last) last_cnt++;
                end
                if (cnt_en && matrix_done) done_cnt++;
            end
        join_none

        // Reset state
        #12;
        chk("reset_valid", {255'd0, row_valid}, 0);
        chk("reset_data", row_data, 0);
        chk("reset_ovf", {255'd0, overflow}, 0);
        rst = 1;

        // Single row, ready high
        row_ready = 1;
        for (int k = 0; k < N; k++) begin
            drv(1, 1, D_W'(k));
            exp_row[k*D_W +: D_W] = D_W'(k);
        end
        idle(1);
        chk("single_valid", {255'd0, row_valid}, 1);
        chk("single_data", row_data, exp_row);
        chk("single_idx", RW'(row_idx), 0);
        idle(1);
        chk("single_consumed", {255'd0, row_valid}, 0);
        chk("single_ovf", {255'd0, overflow}, 0);

        // Backpressure: two rows buffered, 65th element dropped
        do_clear();
        row_ready = 0;
        for (int k = 0; k < 2*N + 1; k++) drv(1, 1, D_W'($urandom));
        idle(1);
        chk("bp_ovf", {255'd0, overflow}, 1);
        chk("bp_idx0", RW'(row_idx), 0);
        row_ready = 1;
        idle(1);
        chk("bp_idx1", RW'(row_idx), 1);
        chk("bp_valid1", {255'd0, row_valid}, 1);
        idle(1);
        chk("bp_drained", {255'd0, row_valid}, 0);

        // Full matrix
        do_clear();
        hs_cnt = 0; done_cnt = 0; last_cnt = 0; cnt_en = 1;
        for (int k = 0; k < N*N; k++) drv(1, 1, D_W'($urandom));
        idle(4);
        cnt_en = 0;
        chk("mat_handshakes", RW'(hs_cnt), N);
        chk("mat_done_pulses", RW'(done_cnt), 1);
        chk("mat_last_rows", RW'(last_cnt), 1);
        chk("mat_ovf", {255'd0, overflow}, 0);

        // Negative extremes
        row_ready = 0;
        for (int k = 0; k < N; k++) begin
            drv(1, 1, (k % 2) ? 8'h7F : 8'h80);
            exp_row[k*D_W +: D_W] = (k % 2) ? 8'h7F : 8'h80;
        end
        idle(1);
        chk("neg_data", row_data, exp_row);
        row_ready = 1;
        idle(2);

        // Enable gaps: disabled cycles must not be captured
        row_ready = 0;
        for (int k = 0; k < 10; k++) drv(1, 1, D_W'(k + 100));
        for (int k = 0; k < 5; k++) drv(1, 0, 8'hEE);
        for (int k = 10; k < N; k++) drv(1, 1, D_W'(k + 100));
        for (int k = 0; k < N; k++) exp_row[k*D_W +: D_W] = D_W'(k + 100);
        idle(1);
        chk("gap_data", row_data, exp_row);
        row_ready = 1;
        idle(2);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, D_W'($urandom));
            row_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 199) == 0);
        end
        clear = 0; row_ready = 1;
        idle(3);

        // Clear mid-row with in_valid: element dropped, overflow cleared
        row_ready = 0;
        for (int k = 0; k < 2*N + 1; k++) drv(1, 1, D_W'($urandom));
        row_ready = 1;
        idle(3);
        for (int k = 0; k < 17; k++) drv(1, 1, 8'h55);
        drv(1, 1, 8'h66);
        clear = 1;
        drv(0, 1, '0);
        clear = 0;
        chk("clr_ovf", {255'd0, overflow}, 0);
        row_ready = 0;
        for (int k = 0; k < N; k++) begin
            drv(1, 1, D_W'(k + 1));
            exp_row[k*D_W +: D_W] = D_W'(k + 1);
        end
        idle(1);
        wait_valid(4);
        chk("clr_row", row_data, exp_row);
        chk("clr_idx", RW'(row_idx), 0);

        // Async reset mid-cycle with a buffered row and overflow set
        for (int k = 0; k < N + 1; k++) drv(1, 1, D_W'($urandom));
        idle(1);
        chk("pre_rst_ovf", {255'd0, overflow}, 1);
        @(posedge clk); #3;
        rst = 0;
        #1;
        chk("arst_valid", {255'd0, row_valid}, 0);
        chk("arst_data", row_data, 0);
        chk("arst_ovf", {255'd0, overflow}, 0);
        @(posedge clk); #1;
        rst = 1;
        row_ready = 1;
        for (int k = 0; k < N - 1; k++) drv(1, 1, D_W'($urandom));
        idle(1);
        chk("arst_no_row", {255'd0, row_valid}, 0);
        drv(1, 1, 8'h11);
        idle(1);
        chk("arst_row_back", {255'd0, row_valid}, 1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
